fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction-fetch stage that sits directly upstream of the control unit. It owns the fetch program counter and issues sequential reads to the synchronous instruction memory. Returned 16-bit words are buffered in a small FIFO together with their addresses. Words are presented to the decoder over a valid/ready handshake. Jump redirects flush the queue, and halt freezes fetching while the queue drains.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- AW, 8, instruction address width
- DW, 16, instruction word width
- RESET_PC, 0, fetch address after reset

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- imem_req  out  1  read request to instruction memory this cycle
- imem_addr  out  AW  read address, valid when imem_req=1
- imem_data  in  DW  read data, valid the cycle after imem_req
- ins_valid  out  1  head of queue holds an instruction
- ins_data  out  DW  head instruction word
- ins_pc  out  AW  address of head instruction
- ins_ready  in  1  decoder accepts head this cycle
- redirect  in  1  jump taken: flush and restart at redirect_pc
- redirect_pc  in  AW  jump target
- halt  in  1  stop issuing new fetches
- count  out  clog2(DEPTH)+1  current FIFO occupancy

## Operation
- State:
  - fetch_pc (AW)
  - in-flight flag pf_valid with its address pf_pc
  - FIFO storage of {pc, word}, with read/write pointers and count
- Issue: imem_req = rst & !redirect & !halt & (count + pf_valid < DEPTH).
  - The credit check counts current occupancy only. A pop in the same cycle does not add credit.
  - On issue: imem_addr = fetch_pc, fetch_pc <= fetch_pc + 1 (mod 2^AW, 255 wraps to 0), pf_valid <= 1, pf_pc <= fetch_pc.
  - With no issue: pf_valid <= 0.
- Capture: when pf_valid=1 and there is no redirect, {pf_pc, imem_data} is written at the FIFO tail. The credit rule guarantees the FIFO can never overflow.
- Pop: occurs when ins_valid & ins_ready & !redirect. The head advances.
  - Push and pop in the same cycle leave count unchanged.
  - A pop on empty is impossible because ins_valid=0.
- ins_valid = (count != 0).
  - ins_data/ins_pc show the head entry when valid.
  - Both are forced to 0 when empty.
- Redirect (highest priority):
  - Same cycle: FIFO is emptied (count <= 0, pointers reset), pf_valid <= 0, and fetch_pc <= redirect_pc.
  - The word returning next cycle from any earlier request is discarded.
  - No request is issued in the redirect cycle, and a concurrent pop is ignored.
  - The first request from redirect_pc is issued the following cycle, if not halted.
- Halt: blocks new requests only.
  - A request already in flight is still captured.
  - The queue keeps draining to the decoder.
  - Redirect is still honoured while halted.
- Reset (rst=0 at an edge):
  - fetch_pc=RESET_PC, pf_valid=0, count=0, pointers=0.
  - imem_req=0 while rst=0, so ins_valid=0, ins_data=0, ins_pc=0.
  - Reset mid-operation discards all queued and in-flight words.

## Timing
- A request in cycle t produces imem_data in cycle t+1. The data is written at the end of t+1, and ins_valid=1 in cycle t+2. Fetch-to-decode latency is 2 cycles.
- First cycle with rst=1: imem_req=1, imem_addr=RESET_PC. First ins_valid appears 2 cycles later.
- With ins_ready held at 1, steady throughput is 1 instruction/cycle and count settles at 1.
- With ins_ready held at 0, the queue fills to DEPTH. The last request is issued when count + pf_valid = DEPTH−1, and imem_req then stays 0.
- After ins_ready returns to 1, the first new request issues only once count + pf_valid < DEPTH. That is 1 cycle after the first pop, because there is no same-cycle credit.
- Redirect asserted in cycle r: ins_valid=0 in r+1, imem_req=1 with imem_addr=redirect_pc in r+1, first redirected instruction valid in r+3.

## Test plan
- Reset release, memory[i]=0xA000+i, ins_ready=1 → ins_valid first high 2 cycles after the first request. Bench receives ins_pc 0,1,2,… with ins_data 0xA000,0xA001,… one per cycle, and count stays ≤1.
- ins_ready=0 for 10 cycles → count reaches 4, imem_req low, no words lost or duplicated. On release, ins_pc continues in sequence and the first new request issues 1 cycle after the first pop.
- Redirect to 0x40 while 3 entries are queued and one request is in flight → next cycle ins_valid=0 and count=0, the in-flight word is discarded, and the next delivered instruction has ins_pc=0x40.
- Halt for 5 cycles mid-stream with ins_ready=1 → the in-flight word still arrives and the queue drains to empty. After release, fetch resumes at the next sequential address with no gap or duplicate.
- fetch_pc at 0xFE streaming → delivered ins_pc sequence is 0xFE, 0xFF, 0x00, 0x01.
- rst=0 for one cycle with the queue full → outputs are all 0 and count=0 immediately after the edge. The next fetch uses address RESET_PC, and stale words are never delivered.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch stage bundle: instruction-memory read port, decoder handshake and
// redirect/halt control. The fetch stage connects as master.
interface fetch_queue_if #(
    parameter int AW    = 8,
    parameter int DW    = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_data;
    logic          ins_valid;
    logic [DW-1:0] ins_data;
    logic [AW-1:0] ins_pc;
    logic          ins_ready;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          halt;
    logic [CW-1:0] count;

    modport master (
        output imem_req, imem_addr, ins_valid, ins_data, ins_pc, count,
        input  imem_data, ins_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  imem_req, imem_addr, ins_valid, ins_data, ins_pc, count,
        output imem_data, ins_ready, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues sequential reads to a
// synchronous instruction memory and buffers {pc, word} pairs for the decoder.
module fetch_queue #(
    parameter int            DEPTH    = 4,
    parameter int            AW       = 8,
    parameter int            DW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input logic            clk,
    input logic            rst,
    fetch_queue_if.master  bus
);
    localparam int            PW    = $clog2(DEPTH);
    localparam int            CW    = PW + 1;
    localparam logic [CW:0]   LIMIT = (CW + 1)'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] word;
    } entry_t;

    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] pf_pc;
    logic          pf_valid;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    entry_t        mem [DEPTH];

    logic [CW:0]   occupancy;
    logic          issue;
    logic          push;
    logic          pop;
    logic          ins_valid;
    entry_t        head;

    // Credit counts queued plus in-flight words; a same-cycle pop adds none,
    // so a returning word always finds a free slot.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, pf_valid};
    assign issue     = rst && !bus.redirect && !bus.halt && (occupancy < LIMIT);
    assign push      = pf_valid && !bus.redirect;
    assign ins_valid = (count != '0);
    assign pop       = ins_valid && bus.ins_ready && !bus.redirect;
    assign head      = ins_valid ? mem[rd_ptr] : '0;

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc;
    assign bus.ins_valid = ins_valid;
    assign bus.ins_data  = head.word;
    assign bus.ins_pc    = head.pc;
    assign bus.count     = count;

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            pf_pc    <= '0;
            pf_valid <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (bus.redirect) begin
            // Flush queue and in-flight word; the stale return next cycle is dropped.
            fetch_pc <= bus.redirect_pc;
            pf_valid <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);

            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);

            if (issue) begin
                fetch_pc <= fetch_pc + AW'(1);
                pf_pc    <= fetch_pc;
                pf_valid <= 1'b1;
            end else begin
                pf_valid <= 1'b0;
            end
        end
    end

    // NOTE: queue storage has no reset; count gates the head mux, so stale
    // contents are never visible and the array can map to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (rst && push) mem[wr_ptr] <= '{pc: pf_pc, word: bus.imem_data};
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && count == CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed phases from the test plan,
// then randomized control, all compared against a queue-based reference model.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 8;
    localparam int DW    = 16;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] word;
    } ent_t;

    logic clk;
    logic rst;

    fetch_queue_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .RESET_PC(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO as a queue, one outstanding fetch, a fetch pointer.
    logic [15:0] mem [256];
    ent_t        q [$];
    logic [7:0]  mpc;
    logic [7:0]  ipc;
    bit          infl;
    bit          last_req;
    logic [7:0]  last_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs, advance model at the edge.
    task automatic step(input bit r, input bit red, input bit h, input bit rdy,
                        input logic [7:0] rpc);
        bit          e_req;
        bit          e_valid;
        logic [15:0] e_data;
        logic [7:0]  e_pc;
        rst             = r;
        bus.redirect    = red;
        bus.halt        = h;
        bus.ins_ready   = rdy;
        bus.redirect_pc = rpc;
        bus.imem_data   = last_req ? mem[last_addr] : 16'($urandom);
        #1;
        e_req   = r && !red && !h && (q.size() + int'(infl) < DEPTH);
        e_valid = (q.size() != 0);
        e_data  = e_valid ? q[0].word : 16'h0;
        e_pc    = e_valid ? q[0].pc : 8'h0;
        check("imem_req", 32'(bus.imem_req), 32'(e_req));
        if (e_req) check("imem_addr", 32'(bus.imem_addr), 32'(mpc));
        check("ins_valid", 32'(bus.ins_valid), 32'(e_valid));
        check("ins_data", 32'(bus.ins_data), 32'(e_data));
        check("ins_pc", 32'(bus.ins_pc), 32'(e_pc));
        check("count", 32'(bus.count), 32'(q.size()));
        last_req  = bus.imem_req;
        last_addr = bus.imem_addr;
        @(posedge clk);
        if (!r) begin
            q.delete();
            infl = 1'b0;
            mpc  = 8'h00;
        end else if (red) begin
            q.delete();
            infl = 1'b0;
            mpc  = rpc;
        end else begin
            if (e_valid && rdy) void'(q.pop_front());
            if (infl) q.push_back('{pc: ipc, word: mem[ipc]});
            infl = e_req;
            if (e_req) begin
                ipc = mpc;
                mpc = mpc + 8'd1;
            end
        end
        #1;
    endtask

    initial begin
        int budget;
        rst             = 1'b0;
        bus.ins_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.halt        = 1'b0;
        bus.redirect_pc = 8'h00;
        bus.imem_data   = 16'h0;
        last_req        = 1'b0;
        last_addr       = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);

        repeat (2) @(posedge clk);
        #1;
        q.delete();
        infl = 1'b0;
        mpc  = 8'h00;
        ipc  = 8'h00;

        // Reset held, then release and stream with the decoder always ready.
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        repeat (12) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);

        // Back-pressure: fill to DEPTH, then release.
        repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("full_after_stall", 32'(bus.count), 32'(DEPTH));
        repeat (8) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);

        // Redirect with three queued entries and one request in flight.
        budget = 0;
        while (!(q.size() == 3 && infl) && budget < 20) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            budget++;
        end
        check("reach_3_queued_1_inflight", 32'(budget < 20), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'($urandom), 8'h40);
        repeat (6) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);

        // Halt mid-stream while the decoder keeps draining.
        repeat (5) step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        check("drained_during_halt", 32'(bus.count), 32'd0);
        repeat (6) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);

        // Address wrap: 0xFE, 0xFF, 0x00, 0x01 ...
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'hFE);
        repeat (8) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);

        // Reset for one cycle with the queue full.
        budget = 0;
        while (q.size() != DEPTH && budget < 20) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            budget++;
        end
        check("reach_full", 32'(budget < 20), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        repeat (8) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);

        // Randomized control mix.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 99) >= 2),
                 1'($urandom_range(0, 99) < 5),
                 1'($urandom_range(0, 99) < 15),
                 1'($urandom_range(0, 99) < 70),
                 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
